rs_syndrome_calc: RTL



---
 rtl/rs_syndrome_calc.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rs_syndrome_calc.sv
// ============================================================================
// Module   : rs_syndrome_calc
// Purpose  : RS(15,11) GF(16) syndrome stage; Horner evaluation of S1..S4.
// Options  : define RS_SYN_ERRCNT_EN to add the saturating ERR_COUNT output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_syndrome_calc #(
  parameter int         N_SYM     = 15,
  parameter logic [4:0] PRIM_POLY = 5'b10011
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SYM_VALID,
  input  logic [3:0]  SYM_IN,
  output logic        BUSY,
  output logic [3:0]  SYM_IDX,
  output logic [15:0] SYN,
  output logic        SYN_VALID,
`ifdef RS_SYN_ERRCNT_EN
  output logic        ERR_DET,
  output logic [7:0]  ERR_COUNT
`else
  output logic        ERR_DET
`endif
);

  localparam logic [3:0] c_IDX_LAST = 4'(N_SYM - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_idx, w_idx_nxt;
  logic [3:0][3:0] r_acc, w_acc_nxt, w_acc_upd;
  logic [15:0]     r_syn, w_syn_nxt;
  logic            r_syn_valid, w_syn_valid_nxt;
  logic            r_err, w_err_nxt;

  // Constant multiply by alpha^n: n shifts, each reduced by the field polynomial.
  function automatic logic [3:0] mul_alpha(input logic [3:0] a, input int n);
    logic [3:0] r;
    r = a;
    for (int i = 0; i < n; i++) begin
      r = {r[2:0], 1'b0} ^ (r[3] ? PRIM_POLY[3:0] : 4'h0);
    end
    return r;
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_acc_nxt       = r_acc;
    w_syn_nxt       = r_syn;
    w_syn_valid_nxt = 1'b0;
    w_err_nxt       = r_err;
    // In IDLE the old accumulator is treated as zero, so the first symbol loads directly.
    for (int j = 0; j < 4; j++) begin
      w_acc_upd[j] = ((r_state == ACCUM) ? mul_alpha(r_acc[j], j + 1) : 4'h0) ^ SYM_IN;
    end
    if (SYM_VALID) begin
      w_acc_nxt = w_acc_upd;
      if (r_state == IDLE) begin
        w_idx_nxt   = 4'd1;
        w_state_nxt = ACCUM;
      end else if (r_idx == c_IDX_LAST) begin
        w_syn_nxt       = w_acc_upd;
        w_err_nxt       = |w_acc_upd;
        w_syn_valid_nxt = 1'b1;
        w_idx_nxt       = 4'd0;
        w_state_nxt     = IDLE;
      end else begin
        w_idx_nxt = r_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_idx       <= 4'd0;
      r_acc       <= '0;
      r_syn       <= 16'h0000;
      r_syn_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_syn       <= w_syn_nxt;
      r_syn_valid <= w_syn_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign BUSY      = (r_state == ACCUM);
  assign SYM_IDX   = r_idx;
  assign SYN       = r_syn;
  assign SYN_VALID = r_syn_valid;
  assign ERR_DET   = r_err;

`ifdef RS_SYN_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err_count <= 8'd0;
    end else if (r_syn_valid && r_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign ERR_COUNT = r_err_count;
`endif

endmodule

`default_nettype wire
